// File: rtl/sergen_pkg.sv
// sergen_pkg: shared types and constants for the multi-channel serial stimulus generator
package sergen_pkg;

    typedef enum logic [1:0] {
        SG_LFSR = 2'd0,
        SG_RAMP = 2'd1,
        SG_EXT  = 2'd2,
        SG_RSVD = 2'd3
    } sg_mode_e;

    // Right-shifting Galois mask for x^32+x^22+x^2+x+1
    localparam logic [31:0] SG_LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] SG_DEFAULT_SEED = 32'hACE1_2468;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sergen_lfsr.sv
// sergen_lfsr: 32-bit Galois LFSR that emits its LSB and advances only on request
module sergen_lfsr
    import sergen_pkg::*;
#(
    parameter logic [31:0] SEED = SG_DEFAULT_SEED
) (
    input  logic sclk,
    input  logic rstn,
    input  logic restart,
    input  logic adv,
    output logic bout
);

    logic [31:0] lfsr;

    assign bout = lfsr[0];

    // Shift right, folding the taps back in when the outgoing bit is 1
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn)
            lfsr <= SEED;
        else if (restart)
            lfsr <= SEED;
        else if (adv)
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? SG_LFSR_TAPS : 32'h0);
    end

endmodule

// File: rtl/sergen_mc.sv
// sergen_mc: TDM serial frame generator (LFSR / ramp / external words); SERGEN_MC_PARITY_EN puts even parity in the last pad bit of each slot
module sergen_mc
    import sergen_pkg::*;
#(
    parameter int          WORD_W    = 16,
    parameter int          SLOT_W    = 32,
    parameter int          NUM_CH    = 2,
    parameter logic [31:0] LFSR_SEED = SG_DEFAULT_SEED
) (
    input  logic                     sclk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [NUM_CH*WORD_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     sdata,
    output logic                     sfs,
    output logic [15:0]              frame_cnt,
    output logic                     underrun
);

    localparam int N  = NUM_CH * SLOT_W;
    localparam int BW = NUM_CH * WORD_W;
    localparam int CW = clog2(N) > 0 ? clog2(N) : 1;
    localparam int IW = clog2(BW) > 0 ? clog2(BW) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state;
    sg_mode_e        mode_q;
    logic [CW-1:0]   bit_cnt;
    logic [BW-1:0]   fbuf, nbuf;
    logic [WORD_W-1:0] ramp;
    logic [IW-1:0]   idx;
    int              slot_i, pos_i;
    logic            last, load, is_data, dbit, obit, lbit, adv;

    assign last    = bit_cnt == CW'(N - 1);
    assign load    = enable && (state == IDLE || last);
    assign s_ready = rstn && load && mode == SG_EXT;
    assign adv     = state == RUN && mode_q == SG_LFSR && is_data;

    sergen_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .sclk    (sclk),
        .rstn    (rstn),
        .restart (1'b0),
        .adv     (adv),
        .bout    (lbit)
    );

    // Locate the current bit within its slot and pick the word bit, MSB first
    always_comb begin
        slot_i  = int'(bit_cnt) / SLOT_W;
        pos_i   = int'(bit_cnt) % SLOT_W;
        is_data = pos_i < WORD_W;
        idx     = is_data ? IW'(slot_i * WORD_W + WORD_W - 1 - pos_i) : '0;
        dbit    = mode_q == SG_LFSR ? lbit : fbuf[idx];
    end

    // Next frame contents; LFSR and reserved modes leave the buffer zero
    always_comb begin
        nbuf = '0;
        for (int c = 0; c < NUM_CH; c++)
            nbuf[c*WORD_W +: WORD_W] = mode == SG_RAMP ? ramp + WORD_W'(c) :
                                       (mode == SG_EXT && s_valid) ? s_data[c*WORD_W +: WORD_W] : '0;
    end

`ifdef SERGEN_MC_PARITY_EN
    logic par;

    if (SLOT_W <= WORD_W) begin : g_bad_slot
        $error("sergen_mc: parity needs SLOT_W > WORD_W");
    end

    // Running even parity of the data bits already sent in this slot
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn)
            par <= 1'b0;
        else if (state == RUN && is_data)
            par <= pos_i == 0 ? dbit : par ^ dbit;
    end

    assign obit = is_data ? dbit : (pos_i == SLOT_W - 1) && par;
`else
    assign obit = is_data && dbit;
`endif

    // Frame sequencer: load at frame boundaries, shift one bit per sclk, stop only at frame end
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mode_q    <= SG_LFSR;
            bit_cnt   <= '0;
            fbuf      <= '0;
            ramp      <= '0;
            sdata     <= 1'b0;
            sfs       <= 1'b0;
            frame_cnt <= 16'd0;
            underrun  <= 1'b0;
        end else begin
            sdata    <= state == RUN && obit;
            sfs      <= state == RUN && bit_cnt == '0;
            underrun <= load && mode == SG_EXT && !s_valid;
            bit_cnt  <= load ? '0 : state == RUN ? bit_cnt + 1'b1 : bit_cnt;
            state    <= load ? RUN : last ? IDLE : state;
            if (load) begin
                mode_q    <= sg_mode_e'(mode);
                fbuf      <= nbuf;
                frame_cnt <= frame_cnt + 16'd1;
                if (mode == SG_RAMP)
                    ramp <= ramp + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sergen_mc.sv
// tb_sergen_mc: directed checks of framing, ramp, external handshake, underrun, graceful stop, async reset and LFSR sequence
module tb_sergen_mc;

    logic        sclk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, sdata, sfs, underrun;
    logic [15:0] frame_cnt;

    int vecs = 0;
    int errs = 0;

    logic [63:0] d, s, r, ef;
    logic [31:0] seq, m;
    logic [15:0] lw0, lw1;

    always #5 sclk = ~sclk;

    sergen_mc #(
        .WORD_W    (16),
        .SLOT_W    (32),
        .NUM_CH    (2),
        .LFSR_SEED (32'hACE1_2468)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .enable    (enable),
        .mode      (mode),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sdata     (sdata),
        .sfs       (sfs),
        .frame_cnt (frame_cnt),
        .underrun  (underrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // Capture n bits; at index 'at' change enable/s_valid just before that edge
    task automatic run_bits(input int n, input int at, input logic en_v, input logic val_v,
                            output logic [63:0] dd, output logic [63:0] ss, output logic [63:0] rr);
        dd = '0;
        ss = '0;
        rr = '0;
        for (int k = 0; k < n; k++) begin
            if (k == at) begin
                enable  = en_v;
                s_valid = val_v;
            end
            tick();
            dd[k] = sdata;
            ss[k] = sfs;
            rr[k] = s_ready;
        end
    endtask

    // Expected serial frame, indexed by bit number on the line
    function automatic logic [63:0] frame_of(input logic [15:0] w0, input logic [15:0] w1);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            f[k]      = w0[15-k];
            f[32 + k] = w1[15-k];
        end
`ifdef SERGEN_MC_PARITY_EN
        f[31] = ^w0;
        f[63] = ^w1;
`endif
        return f;
    endfunction

    initial begin
        // Reference LFSR bit sequence from the seed
        m = 32'hACE1_2468;
        for (int i = 0; i < 32; i++) begin
            seq[i] = m[0];
            m = {1'b0, m[31:1]} ^ (m[0] ? 32'h8020_0003 : 32'h0);
        end
        for (int k = 0; k < 16; k++) begin
            lw0[15-k] = seq[k];
            lw1[15-k] = seq[16 + k];
        end
        ef = frame_of(lw0, lw1);

        mode = 2'd1;
        tick();
        tick();
        chk("reset_sdata", 64'(sdata), 64'd0);
        chk("reset_sfs", 64'(sfs), 64'd0);
        chk("reset_ready", 64'(s_ready), 64'd0);
        chk("reset_fcnt", 64'(frame_cnt), 64'd0);
        chk("reset_underrun", 64'(underrun), 64'd0);

        #2 rstn = 1'b1;
        tick();
        chk("idle_fcnt", 64'(frame_cnt), 64'd0);
        chk("idle_sdata", 64'(sdata), 64'd0);

        enable = 1'b1;
        tick();
        chk("load1_fcnt", 64'(frame_cnt), 64'd1);
        chk("load1_sfs", 64'(sfs), 64'd0);

        run_bits(64, -1, 1'b1, 1'b0, d, s, r);
        chk("ramp_f1", d, frame_of(16'h0000, 16'h0001));
        chk("ramp_f1_sfs", s, 64'd1);
        chk("fcnt_load2", 64'(frame_cnt), 64'd2);

        mode    = 2'd2;
        s_valid = 1'b1;
        s_data  = {16'hBEEF, 16'hA5A5};
        run_bits(64, -1, 1'b1, 1'b1, d, s, r);
        chk("ramp_f2", d, frame_of(16'h0001, 16'h0002));
        chk("f2_sfs", s, 64'd1);
        chk("f2_ready", r, 64'h4000_0000_0000_0000);
        chk("f2_underrun", 64'(underrun), 64'd0);
        chk("fcnt_load3", 64'(frame_cnt), 64'd3);

        run_bits(64, 63, 1'b1, 1'b0, d, s, r);
        chk("ext_f3", d, frame_of(16'hA5A5, 16'hBEEF));
        chk("f3_ready", r, 64'h4000_0000_0000_0000);
        chk("f3_underrun", 64'(underrun), 64'd1);
        chk("fcnt_load4", 64'(frame_cnt), 64'd4);

        run_bits(64, 0, 1'b1, 1'b1, d, s, r);
        chk("ext_f4_zero", d, frame_of(16'h0000, 16'h0000));
        chk("f4_sfs", s, 64'd1);
        chk("f4_ready", r, 64'h4000_0000_0000_0000);
        chk("f4_underrun", 64'(underrun), 64'd0);
        chk("fcnt_load5", 64'(frame_cnt), 64'd5);

        run_bits(64, 10, 1'b0, 1'b1, d, s, r);
        chk("stop_f5", d, frame_of(16'hA5A5, 16'hBEEF));
        chk("stop_sfs", s, 64'd1);
        chk("stop_ready", r, 64'd0);
        chk("stop_fcnt", 64'(frame_cnt), 64'd5);

        run_bits(64, -1, 1'b0, 1'b1, d, s, r);
        chk("idle_data", d, 64'd0);
        chk("idle_sfs", s, 64'd0);
        chk("idle_ready", r, 64'd0);
        chk("idle_fcnt5", 64'(frame_cnt), 64'd5);

        mode   = 2'd0;
        enable = 1'b1;
        tick();
        chk("lfsr_load_fcnt", 64'(frame_cnt), 64'd6);
        run_bits(41, -1, 1'b1, 1'b1, d, s, r);
        chk("lfsr_pre", {23'd0, d[40:0]}, {23'd0, ef[40:0]});

        #3 rstn = 1'b0;
        #1;
        chk("arst_sdata", 64'(sdata), 64'd0);
        chk("arst_sfs", 64'(sfs), 64'd0);
        chk("arst_fcnt", 64'(frame_cnt), 64'd0);
        mode = 2'd2;
        #1;
        chk("arst_ready", 64'(s_ready), 64'd0);
        mode = 2'd0;
        #1 rstn = 1'b1;

        tick();
        chk("rel_sfs", 64'(sfs), 64'd0);
        chk("rel_fcnt", 64'(frame_cnt), 64'd1);
        run_bits(64, -1, 1'b1, 1'b1, d, s, r);
        chk("lfsr_frame", d, ef);
        chk("lfsr_bit32", 64'(d[32]), 64'(seq[16]));
        chk("lfsr_sfs", s, 64'd1);

        enable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
